// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bi, one bit per clock, LSB first.
// A single full-subtractor cell feeds a registered borrow flop; operands are
// loaded with a START/BUSY/VALID/ACK handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output V.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    input  logic             ACK,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Bo,
    output logic             V
`else
    output logic             Bo
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    logic cell_a, cell_b, cell_d, cell_br;

    always_comb begin
        cell_a  = sa_q[0];
        cell_b  = sb_q[0];
        cell_d  = cell_a ^ cell_b ^ br_q;
        cell_br = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br_q);
    end

`ifdef SERIAL_SUB_OVF_EN
    logic v_q, v_d;
    logic cell_v;

    // On the last RUN edge the cell sees the operand MSBs and produces the result MSB.
    always_comb begin
        cell_v = (cell_a != cell_b) && (cell_d != cell_a);
    end
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        v_d     = v_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = Bi;
                    cnt_d   = '0;
                    dsr_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = cell_br;
                dsr_d = {cell_d, dsr_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    bo_d    = cell_br;
`ifdef SERIAL_SUB_OVF_EN
                    v_d     = cell_v;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RST_N) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    // Outputs are decoded straight from registers only.
    always_comb begin
        BUSY  = (state_q == RUN);
        VALID = (state_q == DONE);
        D     = dsr_q;
        Bo    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
        V     = v_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors with
// hand-computed results pushed into a scoreboard, checked by a VALID monitor.
module tb_serial_subtractor;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Bi = 1'b0;
    logic       ACK = 1'b0;
    logic       BUSY, VALID, Bo;
    logic [7:0] D;
`ifdef SERIAL_SUB_OVF_EN
    logic       V;
`endif

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .VALID (VALID),
        .D     (D),
`ifdef SERIAL_SUB_OVF_EN
        .Bo    (Bo),
        .V     (V)
`else
        .Bo    (Bo)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising VALID pops one expected result and compares it.
    always @(negedge CLK) begin
        if (VALID && !valid_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: D=0x%0h Bo=%0b with empty scoreboard", D, Bo);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_D", {24'd0, D}, {24'd0, e.d});
                check("result_Bo", {31'd0, Bo}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
                check("result_V", {31'd0, V}, {31'd0, e.v});
`endif
            end
        end
        valid_prev <= VALID;
    end

    // One full transaction; optional START glitches in RUN and START together with ACK.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ed, input logic ebo, input logic ev,
                         input int hold, input bit glitch, input bit ack_start);
        exp_t e;
        int   busy_cnt;
        logic [7:0] d_hold;
        logic bo_hold;
        e.d = ed; e.bo = ebo; e.v = ev;
        @(negedge CLK);
        A = a; B = b; Bi = bi; START = 1'b1;
        sb_q.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !VALID; i++) begin
            if (BUSY) busy_cnt++;
            if (glitch) begin
                START = (i == 1 || i == 4);
                A = ~a; B = a; Bi = ~bi;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check("valid_reached", {31'd0, VALID}, 32'd1);
        check("busy_cycles", busy_cnt, 32'd8);
        d_hold = D;
        bo_hold = Bo;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check("valid_held", {31'd0, VALID}, 32'd1);
            check("D_held", {24'd0, D}, {24'd0, d_hold});
            check("Bo_held", {31'd0, Bo}, {31'd0, bo_hold});
        end
        ACK = 1'b1;
        if (ack_start) begin
            START = 1'b1; A = 8'h11; B = 8'h22; Bi = 1'b0;
        end
        @(negedge CLK);
        ACK = 1'b0;
        START = 1'b0;
        check("valid_drop", {31'd0, VALID}, 32'd0);
        check("busy_after_ack", {31'd0, BUSY}, 32'd0);
        if (ack_start) begin
            @(negedge CLK);
            check("ack_start_ignored", {31'd0, BUSY}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_BUSY", {31'd0, BUSY}, 32'd0);
        check("rst_VALID", {31'd0, VALID}, 32'd0);
        check("rst_D", {24'd0, D}, 32'd0);
        check("rst_Bo", {31'd0, Bo}, 32'd0);
        RST_N = 1'b1;

        //     A      B      Bi    D      Bo    V     hold glitch ack_start
        issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        issue(8'h77, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        issue(8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0, 1'b1, 0, 1'b1, 1'b1);

        // Reset on the 4th RUN edge discards the partial result.
        @(negedge CLK);
        A = 8'h33; B = 8'h11; Bi = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("abort_BUSY", {31'd0, BUSY}, 32'd0);
        check("abort_VALID", {31'd0, VALID}, 32'd0);
        check("abort_D", {24'd0, D}, 32'd0);
        check("abort_Bo", {31'd0, Bo}, 32'd0);
        repeat (10) @(negedge CLK);
        check("abort_stays_idle", {31'd0, BUSY | VALID}, 32'd0);

        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor: D = A - B - Bi over WIDTH cycles, LSB first.
- One full-subtractor cell with a registered borrow flop.
- Subtract-side companion to the adder cells in the arithmetic library. Trades area for latency in multi-operand datapaths.
- Operands load with a start/busy/valid/ack handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, synchronous, active-low.
- START  input  1  load request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on an accepted START.
- B  input  WIDTH  subtrahend; captured on an accepted START.
- Bi  input  1  borrow-in; captured on an accepted START.
- ACK  input  1  consumer has taken the result; sampled only in DONE.
- BUSY  output  1  high in RUN.
- VALID  output  1  high in DONE.
- D  output  WIDTH  difference; stable while VALID.
- Bo  output  1  final borrow-out (unsigned A < B + Bi); stable while VALID.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is synchronous and active-low.
- Reset (RST_N=0 at an edge):
  - State goes to IDLE.
  - BUSY=0, VALID=0, D=0, Bo=0.
  - Operand shift registers, borrow flop and bit counter go to 0.
  - Reset overrides every other input on that edge, including mid-RUN and mid-DONE; any partial result is discarded.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - START=1 at an edge: capture A→sa, B→sb, Bi→br; clear counter and D shift register; go to RUN.
  - START=0: stay in IDLE.
  - ACK is ignored.
- RUN, each edge:
  - Cell inputs: a=sa[0], b=sb[0], c=br.
  - d = a^b^c.
  - br ← (~a & b) | (~(a^b) & c).
  - sa, sb shift right by 1.
  - d shifts into D[WIDTH-1] while D shifts right.
  - Counter increments.
  - On the edge where counter==WIDTH-1: go to DONE and set Bo ← new br.
  - START and ACK are ignored in RUN.
- DONE:
  - VALID=1; D and Bo hold.
  - ACK=1 at an edge: go to IDLE; VALID=0 next cycle. D and Bo keep their values until the next accepted START clears D.
  - START in the same cycle as ACK is not accepted. A new START is accepted from IDLE at the earliest one cycle later.
- Latency:
  - START sampled at edge t → VALID=1 after edge t+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (ACK held high).
- Timing: outputs are registered; no combinational path from any input to any output.
- Arithmetic: modulo 2^WIDTH. Bo=1 iff A < B + Bi as unsigned.
- Boundary cases:
  - A=B, Bi=0 → D=0, Bo=0.
  - A=0, B=0, Bi=1 → D=all ones, Bo=1.
  - WIDTH-bit all-ones minus all-ones with Bi=1 → D=all ones, Bo=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output V (1 bit): signed two's-complement overflow, V = sa_msb ^ sb_msb computed against the result sign, i.e. V = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]).
  - V is registered on the same edge as Bo, reset to 0, and held with D.
- When undefined:
  - Port V does not exist.
  - No overflow logic is present.

Test Plan:
- WIDTH=8, reset, then START with A=0x5A, B=0x3C, Bi=0 → BUSY for 8 cycles, VALID after edge t+8, D=0x1E, Bo=0.
- A=0x00, B=0x01, Bi=0 → D=0xFF, Bo=1. Hold ACK=0 for 5 cycles → VALID, D and Bo stay constant. Then ACK=1 → VALID=0 next cycle.
- A=0x10, B=0x0F, Bi=1 → D=0x00, Bo=0. Then A=0x00, B=0x00, Bi=1 → D=0xFF, Bo=1.
- Pulse START again at cycles 2 and 5 of RUN with different operands → ignored; result remains that of the first operands. START together with ACK in DONE → not accepted; state returns to IDLE.
- RST_N=0 at the 4th RUN edge → next cycle BUSY=0, VALID=0, D=0, Bo=0. A fresh START with A=0x80, B=0x01 → D=0x7F, Bo=0.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 → V=1. A=0x7F, B=0xFF → D=0x80, V=1. A=0x05, B=0x03 → V=0. Without the macro, the same bench compiles without the V connection and D/Bo match.
